// File: rtl/audio_pkg.sv
// Shared types for the WM8731 transport controller: FSM states, speed direction,
// per-state start/owner decode and speed-code packing.
package audio_pkg;

  localparam int unsigned SPD_CODE_MAX_W = 5;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_PLAY   = 3'd2,
    S_RECORD = 3'd3,
    S_PAUSE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SPD_NORMAL = 2'd0,
    SPD_FAST   = 2'd1,
    SPD_SLOW   = 2'd2
  } speed_dir_e;

  typedef struct packed {
    logic i2c_start;
    logic rec_start;
    logic play_start;
    logic sram_sel;
  } ctrl_t;

  // Start levels and SRAM owner implied by a state.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c            = '0;
    c.i2c_start  = (s == S_INIT);
    c.rec_start  = (s == S_RECORD);
    c.play_start = (s == S_PLAY);
    c.sram_sel   = (s == S_PLAY) || (s == S_PAUSE);
    return c;
  endfunction

  // {slow, speed-1}; caller truncates to its own SPD_W+1.
  function automatic logic [SPD_CODE_MAX_W-1:0] speed_code(input speed_dir_e dir,
                                                          input logic [3:0] mag_m1,
                                                          input int unsigned spd_w);
    logic [SPD_CODE_MAX_W-1:0] slow_bit;
    slow_bit = (dir == SPD_SLOW) ? (SPD_CODE_MAX_W'(1) << spd_w) : '0;
    return slow_bit | SPD_CODE_MAX_W'(mag_m1);
  endfunction

endpackage

// File: rtl/audio_speed_ctrl.sv
// Playback speed tracker: direction plus magnitude (1..MAX_SPEED), stepped by up/down
// pulses while enabled; warns when a step would pass the limit.
module audio_speed_ctrl
  import audio_pkg::*;
#(
  parameter  int unsigned MAX_SPEED = 8,
  localparam int unsigned SPD_W     = $clog2(MAX_SPEED)
) (
  input  logic             i_bclk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_down,
  output logic [SPD_W:0]   o_speed_code,
  output logic             o_speed_warn
);

  localparam logic [SPD_W-1:0] MAG_MAX = SPD_W'(MAX_SPEED - 1);
  localparam logic [SPD_W-1:0] MAG_ONE = SPD_W'(1);

  speed_dir_e       dir, dir_nxt;
  logic [SPD_W-1:0] mag, mag_nxt;
  logic             warn_nxt;

  // mag holds speed-1; up/down together cancel.
  always_comb begin
    dir_nxt  = dir;
    mag_nxt  = mag;
    warn_nxt = 1'b0;
    if (i_en && (i_up ^ i_down)) begin
      case (dir)
        SPD_NORMAL: begin
          dir_nxt = i_up ? SPD_FAST : SPD_SLOW;
          mag_nxt = MAG_ONE;
        end
        SPD_FAST: begin
          if (i_up) begin
            if (mag == MAG_MAX) warn_nxt = 1'b1;
            else                mag_nxt  = mag + MAG_ONE;
          end else if (mag == MAG_ONE) begin
            dir_nxt = SPD_NORMAL;
            mag_nxt = '0;
          end else begin
            mag_nxt = mag - MAG_ONE;
          end
        end
        SPD_SLOW: begin
          if (i_down) begin
            if (mag == MAG_MAX) warn_nxt = 1'b1;
            else                mag_nxt  = mag + MAG_ONE;
          end else if (mag == MAG_ONE) begin
            dir_nxt = SPD_NORMAL;
            mag_nxt = '0;
          end else begin
            mag_nxt = mag - MAG_ONE;
          end
        end
        default: begin
          dir_nxt = SPD_NORMAL;
          mag_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      dir          <= SPD_NORMAL;
      mag          <= '0;
      o_speed_code <= '0;
      o_speed_warn <= 1'b0;
    end else begin
      dir          <= dir_nxt;
      mag          <= mag_nxt;
      o_speed_code <= (SPD_W + 1)'(speed_code(dir_nxt, 4'(mag_nxt), SPD_W));
      o_speed_warn <= warn_nxt;
    end
  end

endmodule

// File: rtl/audio_transport_ctrl.sv
// Record/playback transport sequencer over NUM_SLOTS SRAM regions with per-slot lengths.
// Build option AUDIO_LOOP_PLAY_EN: play-done restarts the take instead of returning to IDLE.
module audio_transport_ctrl
  import audio_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 20,
  parameter  int unsigned NUM_SLOTS = 4,
  parameter  int unsigned MAX_SPEED = 8,
  parameter  int unsigned PROG_W    = 5,
  localparam int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned SPD_W     = $clog2(MAX_SPEED)
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_up,
  input  logic              i_down,
  input  logic              i_mode,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic              i_i2c_done,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_done,
  input  logic [ADDR_W-1:0] i_play_addr,
  input  logic              i_play_done,
  output logic              o_i2c_start,
  output logic              o_rec_start,
  output logic              o_play_start,
  output logic [ADDR_W-1:0] o_start_pos,
  output logic [ADDR_W-1:0] o_end_pos,
  output logic [SPD_W:0]    o_speed_code,
  output logic              o_sram_sel,
  output logic [2:0]        o_state,
  output logic [PROG_W-1:0] o_progress,
  output logic              o_speed_warn
);

  localparam int unsigned       SLOT_LOG  = $clog2(NUM_SLOTS);
  localparam int unsigned       OFF_W     = ADDR_W - SLOT_LOG;
  localparam int unsigned       PROG_SH   = OFF_W - PROG_W;
  localparam logic [ADDR_W-1:0] REGION_M1 = ADDR_W'((64'(1) << OFF_W) - 64'(1));

  function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] s);
    return ADDR_W'(s) << OFF_W;
  endfunction

  // Top PROG_W bits of the slot-relative offset.
  function automatic logic [PROG_W-1:0] rel_prog(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] base_a);
    return PROG_W'((addr - base_a) >> PROG_SH);
  endfunction

  state_e            state;
  ctrl_t             ctrl;
  logic [SLOT_W-1:0] slot;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] len [NUM_SLOTS];

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] cur_len;
  logic              rec_full;
  logic              spd_en;

  assign base     = slot_base(slot);
  assign cur_len  = len[slot];
  assign rec_full = (i_rec_addr == (base + REGION_M1));
  assign spd_en   = (state == S_IDLE) || (state == S_PLAY) || (state == S_PAUSE);

  // Transport FSM; start/owner levels re-derive from state unless a transition overrides them.
  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state      <= S_INIT;
      ctrl       <= state_ctrl(S_INIT);
      slot       <= '0;
      pos        <= '0;
      o_end_pos  <= '0;
      o_progress <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) len[i] <= '0;
    end else begin
      ctrl <= state_ctrl(state);
      case (state)
        S_INIT: begin
          if (i_i2c_done) begin
            state <= S_IDLE;
            ctrl  <= state_ctrl(S_IDLE);
          end
        end
        S_IDLE: begin
          if (i_start) begin
            slot       <= i_slot;
            pos        <= slot_base(i_slot);
            o_end_pos  <= slot_base(i_slot) + len[i_slot];
            o_progress <= '0;
            state      <= i_mode ? S_PLAY : S_RECORD;
            ctrl       <= state_ctrl(i_mode ? S_PLAY : S_RECORD);
          end
        end
        S_PLAY: begin
          if (cur_len == '0) begin
            state      <= S_IDLE;
            ctrl       <= state_ctrl(S_IDLE);
            pos        <= base;
            o_progress <= '0;
          end else if (i_play_done) begin
`ifdef AUDIO_LOOP_PLAY_EN
            pos              <= base;
            o_progress       <= '0;
            ctrl.play_start  <= 1'b0;
`else
            state      <= S_IDLE;
            ctrl       <= state_ctrl(S_IDLE);
            pos        <= base;
            o_progress <= '0;
`endif
          end else if (i_stop) begin
            state      <= S_IDLE;
            ctrl       <= state_ctrl(S_IDLE);
            pos        <= base;
            o_progress <= '0;
          end else if (i_start) begin
            state      <= S_PAUSE;
            ctrl       <= state_ctrl(S_PAUSE);
            pos        <= i_play_addr;
            o_progress <= rel_prog(i_play_addr, base);
          end else if (ctrl.play_start) begin
            // While start is low the Player is re-arming, so its address is stale.
            pos        <= i_play_addr;
            o_progress <= rel_prog(i_play_addr, base);
          end
        end
        S_PAUSE: begin
          if (i_stop) begin
            state      <= S_IDLE;
            ctrl       <= state_ctrl(S_IDLE);
            pos        <= base;
            o_progress <= '0;
          end else if (i_start) begin
            state <= S_PLAY;
            ctrl  <= state_ctrl(S_PLAY);
          end
        end
        S_RECORD: begin
          len[slot]  <= i_rec_addr - base;
          o_end_pos  <= i_rec_addr;
          o_progress <= rel_prog(i_rec_addr, base);
          if (i_rec_done || i_stop || rec_full) begin
            state      <= S_IDLE;
            ctrl       <= state_ctrl(S_IDLE);
            pos        <= base;
            o_progress <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          ctrl  <= state_ctrl(S_IDLE);
        end
      endcase
    end
  end

  audio_speed_ctrl #(
    .MAX_SPEED (MAX_SPEED)
  ) u_speed (
    .i_bclk       (i_bclk),
    .i_rst        (i_rst),
    .i_en         (spd_en),
    .i_up         (i_up),
    .i_down       (i_down),
    .o_speed_code (o_speed_code),
    .o_speed_warn (o_speed_warn)
  );

  assign o_i2c_start  = ctrl.i2c_start;
  assign o_rec_start  = ctrl.rec_start;
  assign o_play_start = ctrl.play_start;
  assign o_sram_sel   = ctrl.sram_sel;
  assign o_start_pos  = pos;
  assign o_state      = state;

endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Directed bench for audio_transport_ctrl (ADDR_W=20, NUM_SLOTS=4, MAX_SPEED=8, PROG_W=5).
module tb_audio_transport_ctrl;
  import audio_pkg::*;

  logic        i_bclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0, i_stop = 1'b0, i_up = 1'b0, i_down = 1'b0, i_mode = 1'b0;
  logic [1:0]  i_slot = '0;
  logic        i_i2c_done = 1'b0, i_rec_done = 1'b0, i_play_done = 1'b0;
  logic [19:0] i_rec_addr = '0, i_play_addr = '0;
  logic        o_i2c_start, o_rec_start, o_play_start, o_sram_sel, o_speed_warn;
  logic [19:0] o_start_pos, o_end_pos;
  logic [3:0]  o_speed_code;
  logic [2:0]  o_state;
  logic [4:0]  o_progress;

  int checks = 0;
  int errors = 0;

  always #5 i_bclk = ~i_bclk;

  audio_transport_ctrl dut (
    .i_bclk(i_bclk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_up(i_up), .i_down(i_down), .i_mode(i_mode), .i_slot(i_slot),
    .i_i2c_done(i_i2c_done), .i_rec_addr(i_rec_addr), .i_rec_done(i_rec_done),
    .i_play_addr(i_play_addr), .i_play_done(i_play_done),
    .o_i2c_start(o_i2c_start), .o_rec_start(o_rec_start), .o_play_start(o_play_start),
    .o_start_pos(o_start_pos), .o_end_pos(o_end_pos), .o_speed_code(o_speed_code),
    .o_sram_sel(o_sram_sel), .o_state(o_state), .o_progress(o_progress),
    .o_speed_warn(o_speed_warn)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_bclk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    // Reset and codec init
    tick(); tick(); tick();
    check("rst_state", 32'(o_state), 32'(S_INIT));
    check("rst_spd", 32'(o_speed_code), 32'h0);
    check("rst_sel", 32'(o_sram_sel), 32'h0);
    check("rst_prog", 32'(o_progress), 32'h0);
    check("rst_starts", 32'({o_rec_start, o_play_start, o_speed_warn}), 32'h0);
    check("rst_end", 32'(o_end_pos), 32'h0);
    i_rst = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      check("init_i2c", 32'(o_i2c_start), 32'h1);
      if (c == 5) i_i2c_done = 1'b1;
      tick();
    end
    i_i2c_done = 1'b0;
    check("init_idle", 32'(o_state), 32'(S_IDLE));
    check("init_i2c_low", 32'(o_i2c_start), 32'h0);

    // Record slot 2 then play it back
    i_rec_addr = 20'h80000; i_slot = 2'd2; i_mode = 1'b0;
    pulse_start();
    check("rec_state", 32'(o_state), 32'(S_RECORD));
    check("rec_start", 32'(o_rec_start), 32'h1);
    check("rec_sel", 32'(o_sram_sel), 32'h0);
    for (int a = 'h80040; a <= 'h800C0; a += 'h40) begin
      i_rec_addr = 20'(a);
      tick();
    end
    check("rec_mid", 32'(o_end_pos), 32'h800C0);
    i_rec_addr = 20'h80100; i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("rec_stop", 32'(o_state), 32'(S_IDLE));
    check("rec_start_low", 32'(o_rec_start), 32'h0);
    i_mode = 1'b1; i_play_addr = 20'h80000;
    pulse_start();
    check("play_state", 32'(o_state), 32'(S_PLAY));
    check("play_startlvl", 32'(o_play_start), 32'h1);
    check("play_sel", 32'(o_sram_sel), 32'h1);
    check("play_spos", 32'(o_start_pos), 32'h80000);
    check("play_epos", 32'(o_end_pos), 32'h80100);

    // Pause / resume, then stop+start on the same cycle
    i_play_addr = 20'h80020;
    tick();
    check("play_track", 32'(o_start_pos), 32'h80020);
    i_play_addr = 20'h80040;
    pulse_start();
    check("pause_state", 32'(o_state), 32'(S_PAUSE));
    check("pause_startlvl", 32'(o_play_start), 32'h0);
    check("pause_sel", 32'(o_sram_sel), 32'h1);
    i_play_addr = 20'h80050;
    tick();
    check("pause_hold", 32'(o_start_pos), 32'h80040);
    pulse_start();
    check("resume_state", 32'(o_state), 32'(S_PLAY));
    check("resume_spos", 32'(o_start_pos), 32'h80040);
    i_stop = 1'b1; i_start = 1'b1;
    tick();
    i_stop = 1'b0; i_start = 1'b0;
    check("stopstart_state", 32'(o_state), 32'(S_IDLE));
    check("stopstart_spos", 32'(o_start_pos), 32'h80000);
    check("stopstart_sel", 32'(o_sram_sel), 32'h0);

    // Speed up to the limit and back down into slow
    for (int i = 1; i <= 8; i++) begin
      i_up = 1'b1; tick(); i_up = 1'b0;
      check("up_code", 32'(o_speed_code), (i <= 7) ? 32'(i) : 32'h7);
      check("up_warn", 32'(o_speed_warn), (i == 8) ? 32'h1 : 32'h0);
    end
    tick();
    check("warn_pulse", 32'(o_speed_warn), 32'h0);
    i_up = 1'b1; i_down = 1'b1; tick(); i_up = 1'b0; i_down = 1'b0;
    check("updown_ign", 32'(o_speed_code), 32'h7);
    for (int j = 1; j <= 7; j++) begin
      i_down = 1'b1; tick(); i_down = 1'b0;
      check("down_code", 32'(o_speed_code), 32'(7 - j));
    end
    i_down = 1'b1; tick(); i_down = 1'b0;
    check("slow2", 32'(o_speed_code), 32'h9);
    i_up = 1'b1; tick(); i_up = 1'b0;
    check("slow_to_norm", 32'(o_speed_code), 32'h0);

    // Record slot 0 until region full; speed ignored while recording
    i_rec_addr = 20'h00000; i_slot = 2'd0; i_mode = 1'b0;
    pulse_start();
    i_rec_addr = 20'h20000; i_up = 1'b1;
    tick();
    i_up = 1'b0;
    check("full_prog", 32'(o_progress), 32'h10);
    check("rec_spd_ign", 32'(o_speed_code), 32'h0);
    check("full_state_mid", 32'(o_state), 32'(S_RECORD));
    i_rec_addr = 20'h3FFFF;
    tick();
    check("full_idle", 32'(o_state), 32'(S_IDLE));
    check("full_epos", 32'(o_end_pos), 32'h3FFFF);
    check("full_prog0", 32'(o_progress), 32'h0);
    i_mode = 1'b1;
    pulse_start();
    check("full_play_epos", 32'(o_end_pos), 32'h3FFFF);
    i_stop = 1'b1; tick(); i_stop = 1'b0;

    // Empty slot: play lasts one cycle
    i_slot = 2'd1;
    pulse_start();
    check("empty_play", 32'(o_state), 32'(S_PLAY));
    tick();
    check("empty_idle", 32'(o_state), 32'(S_IDLE));

    // Play-done: loop restart or return to IDLE; mid-play speed change
    i_slot = 2'd2; i_play_addr = 20'h80000;
    pulse_start();
    i_up = 1'b1; i_play_addr = 20'h80080;
    tick();
    i_up = 1'b0;
    check("midplay_spd", 32'(o_speed_code), 32'h1);
    check("midplay_start", 32'(o_play_start), 32'h1);
    check("midplay_prog", 32'(o_progress), 32'h0);
    i_play_addr = 20'h80100; i_play_done = 1'b1;
    tick();
    i_play_done = 1'b0;
`ifdef AUDIO_LOOP_PLAY_EN
    check("loop_state", 32'(o_state), 32'(S_PLAY));
    check("loop_start_low", 32'(o_play_start), 32'h0);
    check("loop_spos", 32'(o_start_pos), 32'h80000);
    tick();
    check("loop_rearm", 32'(o_play_start), 32'h1);
    check("loop_spos_hold", 32'(o_start_pos), 32'h80000);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    check("loop_stop", 32'(o_state), 32'(S_IDLE));
`else
    check("done_state", 32'(o_state), 32'(S_IDLE));
    check("done_start_low", 32'(o_play_start), 32'h0);
    check("done_spos", 32'(o_start_pos), 32'h80000);
`endif

    // Reset while recording clears lengths and drops starts
    i_slot = 2'd3; i_mode = 1'b0; i_rec_addr = 20'hC0000;
    pulse_start();
    i_rec_addr = 20'hC0010;
    tick();
    i_rst = 1'b1;
    tick();
    check("mrst_rec", 32'(o_rec_start), 32'h0);
    check("mrst_state", 32'(o_state), 32'(S_INIT));
    check("mrst_spd", 32'(o_speed_code), 32'h0);
    i_rst = 1'b0; i_i2c_done = 1'b1;
    tick();
    i_i2c_done = 1'b0;
    i_slot = 2'd2; i_mode = 1'b1;
    pulse_start();
    check("mrst_epos", 32'(o_end_pos), 32'h80000);
    tick();
    check("mrst_len0", 32'(o_state), 32'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
